// File: rtl/psg_pkg.sv
// rtl/psg_pkg.sv - Shared register codes, reset constants and byte formatting for the PSG writer.
package psg_pkg;

    localparam logic [2:0] TONE0 = 3'b000;
    localparam logic [2:0] ATTN0 = 3'b001;
    localparam logic [2:0] TONE1 = 3'b010;
    localparam logic [2:0] ATTN1 = 3'b011;
    localparam logic [2:0] TONE2 = 3'b100;
    localparam logic [2:0] ATTN2 = 3'b101;
    localparam logic [2:0] NOISE = 3'b110;
    localparam logic [2:0] ATTN3 = 3'b111;

    localparam logic [3:0] ATTN_RESET  = 4'hF;
    localparam logic [9:0] TONE_RESET  = 10'd1;
    localparam logic [2:0] NOISE_RESET = 3'b100;

    typedef enum logic [1:0] {
        ENG_IDLE  = 2'd0,
        ENG_PULSE = 2'd1,
        ENG_GAP   = 2'd2
    } eng_state_e;

    typedef struct packed {
        logic [2:0] code;
        logic [9:0] value;
    } psg_cmd_t;

    function automatic logic is_tone(input logic [2:0] code);
        return (code[0] == 1'b0) && (code != NOISE);
    endfunction

    function automatic logic [7:0] latch_byte(input logic [2:0] code, input logic [9:0] value);
        if (code == NOISE) begin
            return {1'b1, NOISE, 1'b0, value[2:0]};
        end
        return {1'b1, code, value[3:0]};
    endfunction

    function automatic logic [7:0] data_byte(input logic [9:0] value);
        return {2'b00, value[9:4]};
    endfunction

endpackage

// File: rtl/psg_bus_writer_if.sv
// rtl/psg_bus_writer_if.sv - Command request handshake between a sequencer and the PSG writer.
interface psg_bus_writer_if;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_reg;
    logic [9:0] req_value;

    modport master (output req_valid, output req_reg, output req_value, input req_ready);
    modport slave  (input req_valid, input req_reg, input req_value, output req_ready);
endinterface

// File: rtl/psg_cmd_fifo.sv
// rtl/psg_cmd_fifo.sv - Synchronous command FIFO with full/empty flags; DEPTH must be a power of two.
module psg_cmd_fifo
    import psg_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push_i,
    input  psg_cmd_t push_data_i,
    input  logic     pop_i,
    output psg_cmd_t head_o,
    output logic     full_o,
    output logic     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    psg_cmd_t    mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end
endmodule

// File: rtl/psg_bus_writer.sv
// rtl/psg_bus_writer.sv - Serialises PSG register commands into latch/data bytes on the /WE bus.
// Define PSG_WRITER_SKIP_REDUNDANT_EN to drop tone/attenuation writes matching the PSG's current state.
module psg_bus_writer
    import psg_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WE_CYCLES  = 1,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    psg_bus_writer_if.slave   req,
    output logic [7:0]        psg_data,
    output logic              psg_we_n,
    output logic              busy
);
    localparam int CNT_MAX = (WE_CYCLES > GAP_CYCLES) ? WE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] WE_LOAD  = CNT_W'(WE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    psg_cmd_t   head;
    logic       fifo_full, fifo_empty;
    logic       pop;
    logic       head_redundant;

    eng_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       data_q, data_d;
    logic             we_n_q, we_n_d;
    logic             pend_q, pend_d;
    logic [7:0]       pend_byte_q, pend_byte_d;
    logic             advance;

    assign req.req_ready = !fifo_full;

    psg_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (req.req_valid),
        .push_data_i ({req.req_reg, req.req_value}),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

`ifdef PSG_WRITER_SKIP_REDUNDANT_EN
    logic [3:0] attn_sh_q [4];
    logic [9:0] tone_sh_q [3];

    always_comb begin
        head_redundant = 1'b0;
        if (head.code[0]) begin
            head_redundant = (head.value[3:0] == attn_sh_q[head.code[2:1]]);
        end else if (is_tone(head.code)) begin
            head_redundant = (head.value == tone_sh_q[head.code[2:1]]);
        end
    end

    // Shadows track only commands that actually reach the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) attn_sh_q[i] <= ATTN_RESET;
            for (int i = 0; i < 3; i++) tone_sh_q[i] <= TONE_RESET;
        end else if (pop && !head_redundant) begin
            if (head.code[0]) begin
                attn_sh_q[head.code[2:1]] <= head.value[3:0];
            end else if (is_tone(head.code)) begin
                tone_sh_q[head.code[2:1]] <= head.value;
            end
        end
    end
`else
    assign head_redundant = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ENG_IDLE;
            cnt_q       <= '0;
            data_q      <= 8'h00;
            we_n_q      <= 1'b1;
            pend_q      <= 1'b0;
            pend_byte_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            we_n_q      <= we_n_d;
            pend_q      <= pend_d;
            pend_byte_q <= pend_byte_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        we_n_d      = we_n_q;
        pend_d      = pend_q;
        pend_byte_d = pend_byte_q;
        pop         = 1'b0;
        advance     = 1'b0;

        case (state_q)
            ENG_IDLE: advance = 1'b1;
            ENG_PULSE: begin
                if (cnt_q == '0) begin
                    we_n_d = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        state_d = ENG_GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ENG_GAP: begin
                if (cnt_q == '0) begin
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = ENG_IDLE;
        endcase

        // End of a byte slot: finish the current command first, then pull the next one.
        if (advance) begin
            if (pend_q) begin
                data_d  = pend_byte_q;
                we_n_d  = 1'b0;
                state_d = ENG_PULSE;
                cnt_d   = WE_LOAD;
                pend_d  = 1'b0;
            end else if (!fifo_empty) begin
                pop = 1'b1;
                if (head_redundant) begin
                    state_d = ENG_IDLE;
                end else begin
                    data_d      = latch_byte(head.code, head.value);
                    we_n_d      = 1'b0;
                    state_d     = ENG_PULSE;
                    cnt_d       = WE_LOAD;
                    pend_d      = is_tone(head.code);
                    pend_byte_d = data_byte(head.value);
                end
            end else begin
                state_d = ENG_IDLE;
            end
        end
    end

    always_comb begin
        psg_data = data_q;
        psg_we_n = we_n_q;
        busy     = !fifo_empty || (state_q != ENG_IDLE);
    end
endmodule

// File: tb/tb_psg_bus_writer.sv
// tb/tb_psg_bus_writer.sv - Randomised bench for psg_bus_writer against a schedule-level bus model.
module tb_psg_bus_writer;
    localparam int DEPTH = 4;
    localparam int W     = 1;
    localparam int G     = 2;
`ifdef PSG_WRITER_SKIP_REDUNDANT_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] psg_data;
    logic       psg_we_n;
    logic       busy;

    psg_bus_writer_if bus();

    psg_bus_writer #(.FIFO_DEPTH(DEPTH), .WE_CYCLES(W), .GAP_CYCLES(G)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (bus),
        .psg_data (psg_data),
        .psg_we_n (psg_we_n),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         s;
        logic [7:0] v;
    } ev_t;

    ev_t        ev_q[$];
    int         pend_q[$];
    int         cyc = 0;
    int         t_free = 0;
    int         t_end = 0;
    logic [7:0] last_data = 8'h00;
    logic [3:0] sh_attn [4] = '{4'hF, 4'hF, 4'hF, 4'hF};
    logic [9:0] sh_tone [4] = '{10'd1, 10'd1, 10'd1, 10'd1};

    int         n_chk = 0;
    int         n_pass = 0;
    int         last_acc = 0;
    int         rdy_low = 0;
    logic       prev_we = 1'b1;
    logic [7:0] obs[$];
    int         obs_cyc[$];

    function automatic logic [7:0] m_latch(input logic [2:0] r, input logic [9:0] v);
        int b;
        if (r == 3'd6) b = 224 + (int'(v) % 8);
        else           b = 128 + int'(r) * 16 + (int'(v) % 16);
        return 8'(b);
    endfunction

    function automatic logic [7:0] m_data(input logic [9:0] v);
        return 8'(int'(v) / 16);
    endfunction

    function automatic int m_occ(input int e);
        int n = 0;
        foreach (pend_q[i]) if (pend_q[i] > e) n++;
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic m_accept(input int k, input logic [2:0] r, input logic [9:0] v);
        int  s;
        bit  tone, drop;
        s    = (k + 1 > t_free) ? k + 1 : t_free;
        tone = (r % 2 == 0) && (r != 3'd6);
        drop = 1'b0;
        if (SKIP && r % 2 == 1 && v[3:0] == sh_attn[r / 2]) drop = 1'b1;
        if (SKIP && tone && v == sh_tone[r / 2]) drop = 1'b1;
        pend_q.push_back(s);
        if (drop) begin
            t_free = s + 1;
        end else begin
            ev_q.push_back('{s, m_latch(r, v)});
            if (tone) ev_q.push_back('{s + W + G, m_data(v)});
            t_free = s + (tone ? 2 : 1) * (W + G);
            t_end  = t_free;
            if (r % 2 == 1) sh_attn[r / 2] = v[3:0];
            if (tone) sh_tone[r / 2] = v;
        end
    endtask

    // Model advances on each active edge from the inputs the bench applied.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            ev_q.delete();
            pend_q.delete();
            last_data = 8'h00;
            t_free = 0;
            t_end  = 0;
            for (int i = 0; i < 4; i++) begin
                sh_attn[i] = 4'hF;
                sh_tone[i] = 10'd1;
            end
        end else if (bus.req_valid && m_occ(cyc - 1) < DEPTH) begin
            m_accept(cyc, bus.req_reg, bus.req_value);
        end
    end

    always @(negedge clk) begin
        logic [7:0] exp_data;
        logic       exp_we;
        int         occ;
        if (cyc > 0) begin
            while (ev_q.size() > 0 && ev_q[0].s + W <= cyc) begin
                last_data = ev_q[0].v;
                void'(ev_q.pop_front());
            end
            exp_we   = 1'b1;
            exp_data = last_data;
            if (ev_q.size() > 0 && ev_q[0].s <= cyc) begin
                exp_we   = 1'b0;
                exp_data = ev_q[0].v;
            end
            while (pend_q.size() > 0 && pend_q[0] <= cyc) void'(pend_q.pop_front());
            occ = pend_q.size();
            check("psg_we_n", 32'(psg_we_n), 32'(exp_we));
            check("psg_data", 32'(psg_data), 32'(exp_data));
            check("busy", 32'(busy), 32'((occ > 0) || (cyc < t_end)));
            check("req_ready", 32'(bus.req_ready), 32'(occ < DEPTH));
            if (!bus.req_ready) rdy_low++;
            if (!psg_we_n && prev_we) begin
                obs.push_back(psg_data);
                obs_cyc.push_back(cyc);
            end
            prev_we = psg_we_n;
        end
    end

    task automatic send(input logic [2:0] r, input logic [9:0] v);
        logic rdy;
        int   n;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_reg   = r;
        bus.req_value = v;
        forever begin
            rdy = bus.req_ready;
            @(negedge clk);
            if (rdy) break;
            n++;
            if (n > 200) begin
                n_chk++;
                $display("FAIL send_timeout: req_ready low for %0d cycles, required acceptance", n);
                break;
            end
        end
        last_acc = cyc;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (cyc > t_free + 1 && cyc > t_end + 1) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) begin
            n_chk++;
            $display("FAIL idle_timeout: engine not idle after 2000 cycles, required idle");
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [9:0] tv [6];
        bus.req_valid = 1'b0;
        bus.req_reg   = 3'd0;
        bus.req_value = 10'd0;
        check("model_pin_noise", 32'(m_latch(3'b110, 10'h2FD)), 32'hE5);
        check("model_pin_tone_data", 32'(m_data(10'h3FE)), 32'h3F);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_we_n", 32'(psg_we_n), 32'h1);
        check("rst_data", 32'(psg_data), 32'h00);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ready", 32'(bus.req_ready), 32'h1);

        obs.delete(); obs_cyc.delete();
        send(3'b000, 10'h3FE);
        wait_idle();
        check("tone0_nbytes", 32'(obs.size()), 32'd2);
        if (obs.size() == 2) begin
            check("tone0_latch", 32'(obs[0]), 32'h8E);
            check("tone0_data", 32'(obs[1]), 32'h3F);
            check("tone0_latency", 32'(obs_cyc[0]), 32'(last_acc + 1));
            check("tone0_spacing", 32'(obs_cyc[1] - obs_cyc[0]), 32'd3);
        end
        check("tone0_busy_end", 32'(busy), 32'h0);

        foreach (tv[i]) tv[i] = (i == 0) ? 10'h005 : 10'h3F5;
        for (int i = 0; i < 2; i++) begin
            pulse_reset();
            obs.delete(); obs_cyc.delete();
            send(3'b111, tv[i]);
            wait_idle();
            check("attn3_nbytes", 32'(obs.size()), 32'd1);
            if (obs.size() == 1) check("attn3_byte", 32'(obs[0]), 32'hF5);
        end

        obs.delete(); obs_cyc.delete();
        send(3'b110, 10'h2FD);
        wait_idle();
        check("noise_nbytes", 32'(obs.size()), 32'd1);
        if (obs.size() == 1) check("noise_byte", 32'(obs[0]), 32'hE5);

        pulse_reset();
        obs.delete(); obs_cyc.delete();
        send(3'b001, 10'h00F);
        send(3'b110, 10'h004);
        send(3'b110, 10'h004);
        wait_idle();
        check("attn0_redundant_nbytes", 32'(obs.size()), SKIP ? 32'd2 : 32'd3);
        if (obs.size() == 3 && !SKIP) check("attn0_byte", 32'(obs[0]), 32'h9F);
        if (obs.size() >= 2) begin
            check("noise_rep_a", 32'(obs[obs.size() - 2]), 32'hE4);
            check("noise_rep_b", 32'(obs[obs.size() - 1]), 32'hE4);
        end

        pulse_reset();
        obs.delete(); obs_cyc.delete();
        rdy_low = 0;
        for (int i = 0; i < 6; i++) tv[i] = 10'(10'h100 + i * 37);
        for (int i = 0; i < 6; i++) send(3'((i % 3) * 2), tv[i]);
        wait_idle();
        check("fifo_full_seen", 32'(rdy_low > 0), 32'h1);
        check("burst_nbytes", 32'(obs.size()), 32'd12);
        if (obs.size() == 12) begin
            for (int i = 0; i < 6; i++) begin
                check("burst_latch", 32'(obs[2 * i]), 32'(m_latch(3'((i % 3) * 2), tv[i])));
                check("burst_data", 32'(obs[2 * i + 1]), 32'(m_data(tv[i])));
            end
        end

        pulse_reset();
        obs.delete(); obs_cyc.delete();
        send(3'b010, 10'h2A7);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_we_n", 32'(psg_we_n), 32'h1);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_ready", 32'(bus.req_ready), 32'h1);
        repeat (10) @(negedge clk);
        check("midrst_nbytes", 32'(obs.size()), 32'd1);
        if (obs.size() == 1) check("midrst_latch", 32'(obs[0]), 32'hA7);

        for (int i = 0; i < 300; i++) begin
            logic [9:0] v;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 59) == 0) pulse_reset();
            v = ($urandom_range(0, 2) == 0) ? 10'($urandom_range(0, 3)) : 10'($urandom);
            send(3'($urandom_range(0, 7)), v);
        end
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
